program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
Boot-time controller that fills the writable program memory (instruction store read by the fetch stage) from a byte stream, such as the UART receiver.
- Frames a length header, assembles little-endian 32-bit words and issues one write per word at word-aligned byte addresses.
- Holds the MIPS core in reset until the load completes.
- Sits between the serial receiver and the program memory write port; the fetch path is untouched.

Parameters:
MEMORY_DEPTH, 32, number of 32-bit words in program memory; loads longer than this are rejected
DATA_WIDTH, 32, instruction and address width; fixed at 32 for the assembler

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
Start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored in other states
ByteIn  input  8  stream byte
ByteValid  input  1  ByteIn is valid this cycle
ByteReady  output  1  loader accepts a byte this cycle; a transfer occurs when ByteValid && ByteReady
MemWrite  output  1  program memory write enable, one cycle per word
MemAddress  output  DATA_WIDTH  byte address, always a multiple of 4 (memory uses Address[DATA_WIDTH-1:2])
MemData  output  DATA_WIDTH  assembled instruction word
CpuHold  output  1  1 = keep processor in reset
Done  output  1  load finished successfully
Error  output  1  header word count exceeded MEMORY_DEPTH

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; word index=0; byte index=0; count=0; assembly register=0.
  - ByteReady=0, MemWrite=0, MemAddress=0, MemData=0, CpuHold=1, Done=0, Error=0.
- Stream format: 16-bit word count N (low byte first), then 4*N bytes. Within each word the first byte is [7:0] and the fourth is [31:24].
- IDLE: ByteReady=0. Start -> LEN_LO.
- LEN_LO: ByteReady=1. On transfer, count[7:0]=ByteIn -> LEN_HI.
- LEN_HI: ByteReady=1. On transfer, count[15:8]=ByteIn, then:
  - N==0 -> DONE.
  - N>MEMORY_DEPTH -> ERROR.
  - otherwise -> DATA.
- DATA: ByteReady=1. On transfer, ByteIn goes into byte lane [byte index] and byte index increments. On the 4th byte -> WRITE, with the byte index wrapping to 0.
- WRITE (exactly one cycle):
  - MemWrite=1, MemAddress=word index*4, MemData=assembled word, ByteReady=0.
  - Next state: if word index==N-1 -> DONE, else word index+1 and back to DATA.
- DONE: CpuHold=0, Done=1, ByteReady=0. Stream bytes are ignored.
- ERROR: Error=1, CpuHold=1, ByteReady=0. No memory writes. Stays until Start or reset.
- Start in DONE or ERROR:
  - Clears Done and Error and zeroes the word index, byte index and count.
  - Goes to LEN_LO on the next cycle with CpuHold=1.
- Start in LEN_LO, LEN_HI, DATA or WRITE: ignored.
- Outputs are registered, so MemWrite is high in the cycle after the 4th byte transfer. Latency from the 4th byte to the write is 1 cycle.
- MemWrite is never high outside WRITE. MemAddress and MemData hold their last values when MemWrite=0.
- CpuHold=1 in every state except DONE.
- ByteValid while ByteReady=0: the byte is not consumed; the upstream source must hold it.
- Reset asserted mid-load: immediate return to IDLE next edge. Memory words already written are left as is; no partial word is written.
- Max N=MEMORY_DEPTH, so the final address is (MEMORY_DEPTH-1)*4. The word index never wraps.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR;
  - byte-lane count constant 4;
  - the count width of 16.
- One natural sub-module, word_assembler:
  - byte index counter plus 32-bit shift/lane register;
  - outputs word_valid on the 4th byte;
  - cleared by the FSM.
- The FSM, word index and header counter stay in the top.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles -> CpuHold=1, Done=0, Error=0, MemWrite=0, ByteReady=0. With no Start, ByteValid bytes are never accepted.
- Two-word load: Start; bytes 02 00, 20 00 08 20, 05 00 09 21. Expect:
  - MemWrite at address 0x0 with data 0x20080020;
  - MemWrite at address 0x4 with data 0x21090005;
  - then Done=1, CpuHold=0;
  - exactly two MemWrite pulses.
- Backpressure: ByteValid held high continuously during the 2-word load -> ByteReady=0 during each WRITE cycle, no byte lost or duplicated, data identical to the previous case.
- Oversize header: N=0x0021 with MEMORY_DEPTH=32 -> Error=1, CpuHold=1, no MemWrite. A later Start plus N=0 -> Done=1, Error=0.
- Full-depth load: N=32, word k=k -> last write at address 0x7C with data 0x0000001F, then Done.
- Reset mid-word: reset=0 after the 2nd data byte of word 1 -> no MemWrite for the partial word, IDLE with CpuHold=1. A Start then restarts the header parse.

Source files
------------

// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the boot-time program memory loader.
package program_memory_loader_pkg;

  // Loader FSM state encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Bytes per 32-bit instruction word
  localparam int LANES = 4;
  localparam int LANE_IDX_WIDTH = $clog2(LANES);

  // Width of the word-count header
  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/program_memory_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The first byte of a
// word lands in [7:0]; word_valid flags the byte that completes a word, and
// word_next is the fully assembled value in that same cycle.
module program_memory_loader_word_assembler
  import program_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_valid
);

  logic [LANE_IDX_WIDTH-1:0] byte_idx;
  logic [DATA_WIDTH-1:0]     word;

  // Insert the incoming byte into its lane and flag the last lane
  always_comb begin
    word_next = word;
    word_next[byte_idx*8 +: 8] = byte_in;
    word_valid = byte_en && (byte_idx == LANE_IDX_WIDTH'(LANES - 1));
  end

  // Lane register and byte index; the index wraps to 0 after the 4th byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 1'b1;
      word     <= word_next;
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Boot loader: parses a 16-bit word-count header from a byte stream, writes
// each assembled word to program memory and holds the CPU in reset until the
// load completes.
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// LEN_LO | waiting for header count byte [7:0]
// LEN_HI | waiting for header count byte [15:8], then range check
// DATA   | collecting the four bytes of the current word
// WRITE  | one-cycle program memory write of the assembled word
// DONE   | load complete, CPU released
// ERROR  | header count exceeded memory depth, CPU held
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(MEMORY_DEPTH);

  state_t                  state, state_next;
  logic [COUNT_WIDTH-1:0]  count, count_next;
  logic [COUNT_WIDTH-1:0]  word_idx, word_idx_next;
  logic [COUNT_WIDTH-1:0]  header;
  logic                    take;
  logic                    asm_clear;
  logic                    asm_byte_en;
  logic [DATA_WIDTH-1:0]   asm_word_next;
  logic                    asm_word_valid;

  logic                    byte_ready_next;
  logic                    mem_write_next;
  logic [DATA_WIDTH-1:0]   mem_address_next;
  logic [DATA_WIDTH-1:0]   mem_data_next;
  logic                    cpu_hold_next;
  logic                    done_next;
  logic                    error_next;

  // ByteReady is registered from the state being entered, so it always
  // matches the current state and can qualify the transfer directly.
  assign take        = ByteReady && ByteValid;
  assign asm_byte_en = take && (state == DATA);
  assign header      = {ByteIn, count[7:0]};

  program_memory_loader_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_en    (asm_byte_en),
    .byte_in    (ByteIn),
    .word_next  (asm_word_next),
    .word_valid (asm_word_valid)
  );

  // Next-state and next-output decode
  always_comb begin
    state_next       = state;
    count_next       = count;
    word_idx_next    = word_idx;
    asm_clear        = 1'b0;
    mem_write_next   = 1'b0;
    mem_address_next = MemAddress;
    mem_data_next    = MemData;
    done_next        = Done;
    error_next       = Error;

    case (state)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          state_next    = LEN_LO;
          asm_clear     = 1'b1;
          count_next    = '0;
          word_idx_next = '0;
          done_next     = 1'b0;
          error_next    = 1'b0;
        end
      end
      LEN_LO: begin
        if (take) begin
          count_next[7:0] = ByteIn;
          state_next      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (take) begin
          count_next[15:8] = ByteIn;
          if (header == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (header > DEPTH_COUNT) begin
            state_next = ERROR;
            error_next = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (asm_word_valid) begin
          state_next       = WRITE;
          mem_write_next   = 1'b1;
          mem_address_next = {{(DATA_WIDTH-COUNT_WIDTH-2){1'b0}}, word_idx, 2'b00};
          mem_data_next    = asm_word_next;
        end
      end
      WRITE: begin
        if (word_idx == count - COUNT_WIDTH'(1)) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          word_idx_next = word_idx + COUNT_WIDTH'(1);
          state_next    = DATA;
        end
      end
      default: state_next = IDLE;
    endcase

    byte_ready_next = (state_next == LEN_LO) || (state_next == LEN_HI) ||
                      (state_next == DATA);
    cpu_hold_next   = (state_next != DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      ByteReady  <= 1'b0;
      MemWrite   <= 1'b0;
      MemAddress <= '0;
      MemData    <= '0;
      CpuHold    <= 1'b1;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      word_idx   <= word_idx_next;
      ByteReady  <= byte_ready_next;
      MemWrite   <= mem_write_next;
      MemAddress <= mem_address_next;
      MemData    <= mem_data_next;
      CpuHold    <= cpu_hold_next;
      Done       <= done_next;
      Error      <= error_next;
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader with a write scoreboard.
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int passed = 0;
  int total  = 0;
  int nwrites = 0;
  logic [63:0] exp_q[$];

  program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .ByteIn     (ByteIn),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .MemWrite   (MemWrite),
    .MemAddress (MemAddress),
    .MemData    (MemData),
    .CpuHold    (CpuHold),
    .Done       (Done),
    .Error      (Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: every write is popped and compared against the queue
  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      logic [63:0] e;
      nwrites++;
      check("byteready_in_write", {31'd0, ByteReady}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", MemAddress, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", MemAddress, e[63:32]);
        check("write_data", MemData, e[31:0]);
      end
    end
  end

  // Present a byte and wait (bounded) until it is accepted; called at a negedge
  task automatic send_byte(input logic [7:0] b);
    int n;
    ByteIn = b;
    ByteValid = 1'b1;
    n = 0;
    while (ByteReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_gap();
    ByteValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n, input bit gaps);
    send_byte(n[7:0]);
    if (gaps) idle_gap();
    send_byte(n[15:8]);
    if (gaps) idle_gap();
  endtask

  // Send one word little-endian and queue the write it must produce
  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit gaps);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0]);
      if (gaps) idle_gap();
    end
  endtask

  task automatic wait_flag(input string tag, input bit want_done);
    int n;
    n = 0;
    while (((want_done ? Done : Error) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (want_done ? Done : Error)}, 32'd1);
  endtask

  initial begin
    int accepted;
    int w0;
    reset = 1'b0;
    Start = 1'b0;
    ByteIn = 8'h00;
    ByteValid = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_cpuhold", {31'd0, CpuHold}, 32'd1);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_byteready", {31'd0, ByteReady}, 32'd0);
    check("rst_memaddr", MemAddress, 32'd0);
    check("rst_memdata", MemData, 32'd0);
    reset = 1'b1;
    ByteValid = 1'b1;
    ByteIn = 8'hA5;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ByteReady === 1'b1) accepted++;
    end
    ByteValid = 1'b0;
    check("idle_no_accept", accepted, 32'd0);
    check("idle_no_write", nwrites, 32'd0);

    // Two-word load with gaps between bytes
    pulse_start();
    check("start_cpuhold", {31'd0, CpuHold}, 32'd1);
    send_header(16'd2, 1'b1);
    send_word(32'h0, 32'h2008_0020, 1'b1);
    send_word(32'h4, 32'h2109_0005, 1'b1);
    wait_flag("two_word_done", 1'b1);
    check("two_word_cpuhold", {31'd0, CpuHold}, 32'd0);
    check("two_word_nwrites", nwrites, 32'd2);
    check("two_word_q_empty", exp_q.size(), 32'd0);
    check("done_memaddr_hold", MemAddress, 32'h4);
    check("done_memdata_hold", MemData, 32'h2109_0005);

    // Bytes offered in DONE are ignored
    ByteValid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ByteReady === 1'b1) accepted++;
    end
    check("done_ignores_bytes", accepted, 32'd0);

    // Same load with ByteValid held high throughout
    w0 = nwrites;
    pulse_start();
    check("restart_done_clr", {31'd0, Done}, 32'd0);
    send_header(16'd2, 1'b0);
    send_word(32'h0, 32'h2008_0020, 1'b0);
    send_word(32'h4, 32'h2109_0005, 1'b0);
    ByteValid = 1'b0;
    wait_flag("bp_done", 1'b1);
    check("bp_nwrites", nwrites - w0, 32'd2);
    check("bp_q_empty", exp_q.size(), 32'd0);

    // Oversize header then N=0 recovery
    w0 = nwrites;
    pulse_start();
    send_header(16'h0021, 1'b0);
    ByteValid = 1'b0;
    wait_flag("oversize_error", 1'b0);
    repeat (3) @(negedge clk);
    check("oversize_cpuhold", {31'd0, CpuHold}, 32'd1);
    check("oversize_done", {31'd0, Done}, 32'd0);
    check("oversize_byteready", {31'd0, ByteReady}, 32'd0);
    check("oversize_nwrites", nwrites - w0, 32'd0);
    pulse_start();
    check("err_clear", {31'd0, Error}, 32'd0);
    send_header(16'h0000, 1'b0);
    ByteValid = 1'b0;
    wait_flag("zero_len_done", 1'b1);
    check("zero_len_error", {31'd0, Error}, 32'd0);
    check("zero_len_nwrites", nwrites - w0, 32'd0);

    // Full-depth load, word k = k
    w0 = nwrites;
    pulse_start();
    send_header(16'd32, 1'b0);
    for (int k = 0; k < 32; k++) send_word(32'(k * 4), 32'(k), 1'b0);
    ByteValid = 1'b0;
    wait_flag("full_done", 1'b1);
    check("full_nwrites", nwrites - w0, 32'd32);
    check("full_last_addr", MemAddress, 32'h7C);
    check("full_last_data", MemData, 32'h1F);

    // Reset during word 1 after two of its bytes
    w0 = nwrites;
    pulse_start();
    send_header(16'd2, 1'b0);
    send_word(32'h0, 32'h1111_2222, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    ByteValid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_nwrites", nwrites - w0, 32'd1);
    check("midrst_cpuhold", {31'd0, CpuHold}, 32'd1);
    check("midrst_byteready", {31'd0, ByteReady}, 32'd0);
    check("midrst_done", {31'd0, Done}, 32'd0);
    pulse_start();
    send_header(16'd1, 1'b0);
    send_word(32'h0, 32'hDEAD_BEEF, 1'b0);
    ByteValid = 1'b0;
    wait_flag("midrst_reload_done", 1'b1);
    check("midrst_reload_nwrites", nwrites - w0, 32'd2);
    check("final_q_empty", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
